// File: rtl/button_event_ctrl.sv
// Button event controller: turns NBTN debounced button levels into a stream of
// PRESS / REPEAT / RELEASE events delivered over a valid/ready handshake.
// Also produces the sample_tick strobe used as clock enable by the debouncers.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   btn_db       debounced button levels, 1 = pressed
//   sample_tick  one-cycle strobe every TICK_DIV clocks
//   evt_valid    an event is presented on evt_btn / evt_type
//   evt_ready    consumer accepts the event when evt_valid && evt_ready
//   evt_btn      index of the button that produced the event
//   evt_type     00 PRESS, 01 REPEAT, 10 RELEASE
//   overrun      sticky flag, set when a REPEAT had to be dropped
//   clr_overrun  clears overrun (a coincident new drop wins)
module button_event_ctrl #(
    parameter int unsigned NBTN         = 4,
    parameter int unsigned TICK_DIV     = 10000,
    parameter int unsigned HOLD_TICKS   = 2500,
    parameter int unsigned REPEAT_TICKS = 500,
    localparam int unsigned BTN_W       = (NBTN > 1) ? $clog2(NBTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBTN-1:0]  btn_db,
    output logic             sample_tick,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [BTN_W-1:0] evt_btn,
    output logic [1:0]       evt_type,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_REPEAT  = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [NBTN-1:0]   btn_q;
    logic [NBTN-1:0]   rise;
    logic [NBTN-1:0]   fall;

    state_t            state_q  [NBTN];
    logic [CNT_W-1:0]  hold_cnt [NBTN];

    logic [NBTN-1:0]   set_press;
    logic [NBTN-1:0]   set_rpt;
    logic [NBTN-1:0]   set_rel;

    logic [NBTN-1:0]   pend_press;
    logic [NBTN-1:0]   pend_rpt;
    logic [NBTN-1:0]   pend_rel;
    logic [NBTN-1:0]   req;

    logic [BTN_W-1:0]  rr;
    logic [BTN_W-1:0]  idx;
    logic [BTN_W-1:0]  gnt;
    logic              found;
    logic              load;
    logic              grant_en;
    logic [1:0]        gnt_type;
    logic [NBTN-1:0]   gnt_oh;
    logic [NBTN-1:0]   clr_press;
    logic [NBTN-1:0]   clr_rpt;
    logic [NBTN-1:0]   clr_rel;
    logic [NBTN-1:0]   drop;

    // Free-running tick divider; sample_tick is high while the count is TICK_DIV-1.
    assign tick_cnt_d = (tick_cnt == TICK_W'(TICK_DIV - 1)) ? '0 : tick_cnt + TICK_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            tick_cnt    <= tick_cnt_d;
            sample_tick <= (tick_cnt_d == TICK_W'(TICK_DIV - 1));
        end
    end

    // Loads in reset too, so a button held through reset is not seen as a rise.
    always_ff @(posedge clk) begin
        btn_q <= btn_db;
    end

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

    // Per-button event decode; a fall pre-empts any coincident tick.
    always_comb begin
        set_press = '0;
        set_rpt   = '0;
        set_rel   = '0;
        for (int i = 0; i < NBTN; i++) begin
            set_press[i] = (state_q[i] == ST_IDLE) && rise[i];
            set_rel[i]   = (state_q[i] != ST_IDLE) && fall[i];
            set_rpt[i]   = (state_q[i] != ST_IDLE) && !fall[i] && sample_tick &&
                           (hold_cnt[i] == ((state_q[i] == ST_HELD) ? CNT_W'(HOLD_TICKS - 1)
                                                                    : CNT_W'(REPEAT_TICKS - 1)));
        end
    end

    // Per-button IDLE / HELD / RPT state machines with hold counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i]  <= ST_IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (set_press[i]) begin
                            state_q[i]  <= ST_HELD;
                            hold_cnt[i] <= '0;
                        end
                    end
                    ST_HELD, ST_RPT: begin
                        if (set_rel[i]) begin
                            state_q[i] <= ST_IDLE;
                        end else if (set_rpt[i]) begin
                            state_q[i]  <= ST_RPT;
                            hold_cnt[i] <= '0;
                        end else if (sample_tick) begin
                            hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign req = pend_press | pend_rpt | pend_rel;

    // Round-robin search starting at rr.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NBTN; k++) begin
            idx = BTN_W'((32'(rr) + 32'(k)) % NBTN);
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Output register may load when empty or when its current event is taken.
    assign load     = !evt_valid || evt_ready;
    assign grant_en = load && found;
    assign gnt_oh   = NBTN'(1) << gnt;
    assign gnt_type = pend_press[gnt] ? EVT_PRESS :
                      pend_rpt[gnt]   ? EVT_REPEAT : EVT_RELEASE;

    assign clr_press = (grant_en && gnt_type == EVT_PRESS)   ? gnt_oh : '0;
    assign clr_rpt   = (grant_en && gnt_type == EVT_REPEAT)  ? gnt_oh : '0;
    assign clr_rel   = (grant_en && gnt_type == EVT_RELEASE) ? gnt_oh : '0;

    // A REPEAT is lost only if one is still pending and not leaving this cycle.
    assign drop = set_rpt & pend_rpt & ~clr_rpt;

    // Pending bits (set wins over clear), arbiter pointer, output register, overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_press <= '0;
            pend_rpt   <= '0;
            pend_rel   <= '0;
            rr         <= '0;
            evt_valid  <= 1'b0;
            evt_btn    <= '0;
            evt_type   <= 2'b00;
            overrun    <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | set_press;
            pend_rpt   <= (pend_rpt & ~clr_rpt & ~set_rel) | set_rpt;
            pend_rel   <= (pend_rel & ~clr_rel) | set_rel;

            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_btn  <= gnt;
                    evt_type <= gnt_type;
                    rr       <= (gnt == BTN_W'(NBTN - 1)) ? '0 : gnt + BTN_W'(1);
                end
            end

            if (|drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
